aes_decrypt_serial: RTL
=======================

# aes_decrypt_serial

Byte-serial AES-128 inverse cipher, the receive-side counterpart of the byte-serial encryption core. It accepts a 16-byte ciphertext block one byte per accepted cycle and runs the ten FIPS-197 inverse rounds on an internal 128-bit state register. It pulls round-key bytes from an external key store through an address interface, and presents the 128-bit plaintext with a one-cycle done pulse.

## Interface
- No parameters. Nr = 10 and Nb = 4 are fixed constants.
- clock  in  1  sole clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  starts a block; sampled in IDLE only.
- in  in  8  ciphertext byte; bytes arrive MSB-first (byte 0 = bits 127:120).
- in_valid  in  1  `in` is valid this cycle.
- in_ready  out  1  high in LOAD; a byte is accepted when in_valid && in_ready. Reset 0.
- key  in  8  round-key byte at key_round/key_idx; combinational read, must be valid in the same cycle. No other timing or handshake applies to this input.
- key_round  out  4  round-key number requested (10..0). Reset 0.
- key_idx  out  4  byte index within that round key (0..15, MSB-first). Reset 0.
- busy  out  1  high in every state except IDLE. Reset 0.
- done  out  1  one-cycle pulse; message valid. Reset 0.
- message  out  128  plaintext, updated only on entry to DONE, held otherwise. Reset 0.

## Operation
- State byte i = state[127-8i -: 8]. Row = i mod 4, column = i div 4.
- FSM states: IDLE, LOAD, INV_SHIFT, INV_SUB, ADD_RK, INV_MIX, DONE.
- IDLE: on start, set byte counter = 0 and round = 10, then go to LOAD.
- LOAD: key_round = 10, key_idx = counter. On each accepted byte, state byte[counter] = in ^ key and counter increments. Stalls while in_valid is low. After byte 15 is accepted, set round = 9 and go to INV_SHIFT.
- INV_SHIFT: one cycle. The whole register is permuted: new(r,c) = old(r,(c−r) mod 4).
- INV_SUB: 16 cycles. Byte[counter] = inv_sbox(byte[counter]).
- ADD_RK: 16 cycles. key_round = round, key_idx = counter, byte[counter] ^= key.
  - If round ≠ 0, go to INV_MIX.
  - If round = 0, go to DONE.
- INV_MIX: 4 cycles. Column c = counter is multiplied by the circulant matrix {0e,0b,0d,09} in GF(2^8), reduction polynomial 0x11B. Then round decrements and the FSM goes to INV_SHIFT.
- DONE: one cycle. done = 1 and message = state. Next state is IDLE.
- The byte/column counter is 4 bits and wraps to 0 on every state exit.
- key_round and key_idx hold their last value outside LOAD and ADD_RK.
- Boundary conditions:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored, and `in` is not consumed.
  - start and in_valid in the same IDLE cycle: that byte is not accepted.
  - reset_n low at any point: immediately returns to IDLE and clears state, counters, outputs, and message. No partial result is ever presented.

## Timing
- LOAD lasts ≥ 16 cycles; exactly 16 with in_valid held high.
- Per-round cost:
  - Rounds 9..1: 1 + 16 + 16 + 4 = 37 cycles each.
  - Round 0: 33 cycles.
- Cycle 1 after the edge that accepts byte 15 is INV_SHIFT. The final ADD_RK ends at cycle 366. done is high in cycle 367.
- Minimum start-to-start period: 1 + 16 + 366 + 1 = 384 cycles.
- The cycle after DONE is IDLE. start there begins the next block, so back-to-back operation has no extra gap.

## Structure
- Package aes_pkg:
  - FSM state enum.
  - Constants NR = 10, NB = 4, BLOCK_BYTES = 16.
  - Functions xtime(b) and gmul(a,b) (GF(2^8), 0x11B).
  - Function inv_shift_rows(state).
- Sub-module inv_sbox: a pure combinational 256-entry ROM, 8-bit in and out. One instance.
- Inverse MixColumns is a combinational function on one 32-bit column, using package gmul.

## Test plan
All vectors are FIPS-197, with the bench key store holding the expanded round keys.
- FIPS-197 C.1: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, in_valid continuous -> message 00112233445566778899aabbccddeeff, with done exactly 367 cycles after byte 15 is accepted.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32, in_valid deasserted randomly during LOAD -> message 3243f6a8885a308d313198a2e0370734; result is independent of the stall pattern.
- Key address trace -> key_round/key_idx sequence is:
  - 10/0..15 during LOAD;
  - then r/0..15 for r = 9 down to 0, only in ADD_RK.
- start pulsed mid-block and in_valid pulsed outside LOAD -> no effect. Result and done timing match the C.1 run.
- reset_n asserted during round 5 ADD_RK -> all outputs 0 immediately, FSM in IDLE, no done. A following C.1 block then decrypts correctly.
- Two C.1/B blocks back-to-back with start in the cycle after DONE -> two correct results; done pulses are 384 cycles apart.

Source files
------------

// File: rtl/aes_decrypt_serial_pkg.sv
// rtl/aes_decrypt_serial_pkg.sv - constants, FSM encoding and GF(2^8) helpers for the byte-serial AES inverse cipher
package aes_pkg;
  localparam int NR          = 10;
  localparam int NB          = 4;
  localparam int BLOCK_BYTES = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_INV_SHIFT = 3'd2;
  localparam logic [2:0] ST_INV_SUB   = 3'd3;
  localparam logic [2:0] ST_ADD_RK    = 3'd4;
  localparam logic [2:0] ST_INV_MIX   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // byte i sits at bits 127-8i, row = i mod 4, column = i div 4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + 4 - row) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
endpackage

// File: rtl/aes_decrypt_serial_inv_sbox.sv
// rtl/aes_decrypt_serial_inv_sbox.sv - AES inverse S-box as a combinational 256-entry ROM
module inv_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  localparam logic [7:0] ROM [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign data = ROM[addr];
endmodule

// File: rtl/aes_decrypt_serial.sv
// rtl/aes_decrypt_serial.sv - byte-serial AES-128 inverse cipher with external round-key store
module aes_decrypt_serial
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   key,
  output logic [3:0]   key_round,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] message
);
  logic [2:0]   fsm;
  logic [3:0]   cnt;
  logic [3:0]   round;
  logic [127:0] state;
  logic [3:0]   key_round_q;
  logic [3:0]   key_idx_q;

  logic [3:0]   byte_pos;
  logic [6:0]   byte_sh;
  logic [6:0]   col_sh;
  logic [7:0]   cur_byte;
  logic [31:0]  cur_col;
  logic [7:0]   sub_byte;
  logic [7:0]   wr_byte;
  logic [127:0] state_byte_wr;
  logic [127:0] state_col_wr;

  assign in_ready = (fsm == ST_LOAD);
  assign busy     = (fsm != ST_IDLE);

  // byte counter walks MSB-first, so byte i lives 8*(15-i) bits above bit 0
  assign byte_pos = 4'd15 - cnt;
  assign byte_sh  = {byte_pos, 3'b000};
  assign col_sh   = {2'd3 - cnt[1:0], 5'b00000};
  assign cur_byte = 8'(state >> byte_sh);
  assign cur_col  = 32'(state >> col_sh);

  inv_sbox u_inv_sbox (
    .addr (cur_byte),
    .data (sub_byte)
  );

  always_comb begin
    wr_byte = cur_byte ^ key;
    if (fsm == ST_LOAD)         wr_byte = in ^ key;
    else if (fsm == ST_INV_SUB) wr_byte = sub_byte;
  end

  assign state_byte_wr = (state & ~(128'hff << byte_sh)) | ({120'd0, wr_byte} << byte_sh);
  assign state_col_wr  = (state & ~({96'd0, 32'hffff_ffff} << col_sh))
                       | ({96'd0, inv_mix_column(cur_col)} << col_sh);

  // the key store is read combinationally, so the address follows the counter in the same cycle
  always_comb begin
    key_round = key_round_q;
    key_idx   = key_idx_q;
    if (fsm == ST_LOAD) begin
      key_round = 4'(NR);
      key_idx   = cnt;
    end else if (fsm == ST_ADD_RK) begin
      key_round = round;
      key_idx   = cnt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm         <= ST_IDLE;
      cnt         <= 4'd0;
      round       <= 4'd0;
      state       <= '0;
      key_round_q <= 4'd0;
      key_idx_q   <= 4'd0;
      done        <= 1'b0;
      message     <= '0;
    end else begin
      done        <= 1'b0;
      key_round_q <= key_round;
      key_idx_q   <= key_idx;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            cnt   <= 4'd0;
            round <= 4'(NR);
            fsm   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            state <= state_byte_wr;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'(BLOCK_BYTES - 1)) begin
              round <= 4'(NR - 1);
              fsm   <= ST_INV_SHIFT;
            end
          end
        end
        ST_INV_SHIFT: begin
          state <= inv_shift_rows(state);
          cnt   <= 4'd0;
          fsm   <= ST_INV_SUB;
        end
        ST_INV_SUB: begin
          state <= state_byte_wr;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(BLOCK_BYTES - 1)) fsm <= ST_ADD_RK;
        end
        ST_ADD_RK: begin
          state <= state_byte_wr;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(BLOCK_BYTES - 1)) begin
            if (round == 4'd0) begin
              message <= state_byte_wr;
              done    <= 1'b1;
              fsm     <= ST_DONE;
            end else begin
              fsm <= ST_INV_MIX;
            end
          end
        end
        ST_INV_MIX: begin
          state <= state_col_wr;
          if (cnt == 4'(NB - 1)) begin
            cnt   <= 4'd0;
            round <= round - 4'd1;
            fsm   <= ST_INV_SHIFT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: begin
          cnt <= 4'd0;
          fsm <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end
endmodule
